// File: rtl/sram_req_bridge_if.sv
// sram_req_bridge_if: request/response valid-ready bundle between a core and sram_req_bridge.
interface sram_req_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_req_bridge.sv
// sram_req_bridge: registered request stage for an OpenRAM RW port with a credit-limited FWFT read response FIFO.
// Optional SRAM_REQ_BRIDGE_STATS_EN adds saturating accepted read/write counters.
module sram_req_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_req_bridge_if.slave      bus,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
`ifdef SRAM_REQ_BRIDGE_STATS_EN
  ,
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_wr_cnt
`endif
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH = CW'(RESP_DEPTH);
  logic                  r_live;
  logic                  r_rd_p1;
  logic                  r_rd_p2;
  logic [CW-1:0]         r_credit;
  logic [CW-1:0]         r_cnt;
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];
  logic                  w_acc;
  logic                  w_rd_acc;
  logic                  w_pop;
  // r_live holds ready low until the first edge after reset release
  always_comb begin
    bus.req_ready = r_live && (r_credit < DEPTH);
    w_acc         = bus.req_valid && bus.req_ready;
    w_rd_acc      = w_acc && !bus.req_we;
    bus.rsp_valid = r_cnt != '0;
    w_pop         = bus.rsp_valid && bus.rsp_ready;
    bus.rsp_rdata = r_mem[r_rp];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_live     <= 1'b0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else begin
      r_live   <= 1'b1;
      sram_csb <= !w_acc;
      sram_web <= !(w_acc && bus.req_we);
      if (w_acc) begin
        sram_wmask <= bus.req_wmask;
        sram_addr  <= bus.req_addr;
        sram_din   <= bus.req_wdata;
      end
    end
  // credits count pipeline plus FIFO occupancy, so a push always finds room
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_p1  <= 1'b0;
      r_rd_p2  <= 1'b0;
      r_credit <= '0;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else begin
      r_rd_p1  <= w_rd_acc;
      r_rd_p2  <= r_rd_p1;
      r_credit <= r_credit + CW'(w_rd_acc) - CW'(w_pop);
      r_cnt    <= r_cnt + CW'(r_rd_p2) - CW'(w_pop);
      if (r_rd_p2) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (r_rd_p2) r_mem[r_wp] <= sram_dout;
`ifdef SRAM_REQ_BRIDGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (w_rd_acc && stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      if (w_acc && bus.req_we && stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
    end
`endif
  a_credit_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rd_acc && !w_pop && r_credit == DEPTH));
  a_credit_udf: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_pop && !w_rd_acc && r_credit == '0));
  a_fifo_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_rd_p2 && !w_pop && r_cnt == DEPTH));
endmodule

// File: tb/tb_sram_req_bridge.sv
// tb_sram_req_bridge: randomized self-checking bench with a behavioural SRAM and an ordered-response reference model.
module tb_sram_req_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;
`ifdef SRAM_REQ_BRIDGE_STATS_EN
  logic [15:0] stat_rd_cnt, stat_wr_cnt;
`endif
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] sram_mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic        cap_csb = 1'b1;
  logic        cap_web = 1'b1;
  logic [3:0]  cap_m;
  logic [7:0]  cap_a;
  logic [31:0] cap_d;

  sram_req_bridge_if bus ();

  sram_req_bridge dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
`ifdef SRAM_REQ_BRIDGE_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM macro: inputs captured at posedge, write commit and read data at the following negedge
  always @(posedge clk) begin
    cap_csb <= sram_csb;
    cap_web <= sram_web;
    cap_m   <= sram_wmask;
    cap_a   <= sram_addr;
    cap_d   <= sram_din;
  end
  always @(negedge clk) begin
    if (!cap_csb && !cap_web)
      for (int b = 0; b < 4; b++)
        if (cap_m[b]) sram_mem[cap_a][8*b +: 8] <= cap_d[8*b +: 8];
    sram_dout <= (!cap_csb && cap_web) ? sram_mem[cap_a] : 32'hxxxxxxxx;
  end

  always @(negedge clk) begin
    #2;
    if (bus.rsp_valid && bus.rsp_ready) got_q.push_back(bus.rsp_rdata);
  end

  task automatic send(input logic we, input logic [3:0] m, input logic [7:0] a,
                      input logic [31:0] d, output int stalls);
    stalls = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_wmask = m;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && stalls < 100) begin
      if (stalls >= 3) bus.rsp_ready = 1'b1;
      @(negedge clk);
      stalls++;
    end
    if (!bus.req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: req_ready stayed %b, required 1", bus.req_ready);
    end else if (we) begin
      for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end else exp_q.push_back(ref_mem[a]);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (got_q.size() < exp_q.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sram_csb, sram_web, sram_wmask, sram_addr, sram_din} !== {2'b11, 4'h0, 8'h00, 32'h0}) begin
      n_err++;
      $display("FAIL reset_sram: csb=%b web=%b m=%h a=%h d=%h, required 1 1 0 0 0",
               sram_csb, sram_web, sram_wmask, sram_addr, sram_din);
    end
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_hs: ready=%b rsp_valid=%b, required 0 0", bus.req_ready, bus.rsp_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b, required 1", bus.req_ready);
    end
  endtask

  task automatic test_fill();
    int st;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(1'b1, 4'hF, 8'(i), $urandom, st);
    n_cmp++;
    if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_addr !== 8'hFF) begin
      n_err++;
      $display("FAIL fill_drive: csb=%b web=%b a=%h, required 0 0 ff", sram_csb, sram_web, sram_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int st;
    exp_q.delete(); got_q.delete();
    bus.rsp_ready = 1'b0;
    send(1'b1, 4'hF, 8'h10, 32'hDEADBEEF, st);
    n_cmp++;
    if ({sram_csb, sram_web, sram_wmask, sram_addr, sram_din} !== {2'b00, 4'hF, 8'h10, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL basic_wr_drive: csb=%b web=%b m=%h a=%h d=%h, required 0 0 f 10 deadbeef",
               sram_csb, sram_web, sram_wmask, sram_addr, sram_din);
    end
    send(1'b0, 4'h0, 8'h10, 32'h0, st);
    n_cmp++;
    if ({sram_csb, sram_web, bus.rsp_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL basic_rd_drive: csb=%b web=%b rsp_valid=%b, required 0 1 0", sram_csb, sram_web, bus.rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_lat1: rsp_valid=%b, required 0", bus.rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL basic_lat2: rsp_valid=%b data=%h, required 1 deadbeef", bus.rsp_valid, bus.rsp_rdata);
    end
    n_cmp++;
    if ({sram_csb, sram_web, sram_addr} !== {2'b11, 8'h10}) begin
      n_err++;
      $display("FAIL basic_idle: csb=%b web=%b a=%h, required 1 1 10", sram_csb, sram_web, sram_addr);
    end
    drain();
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_err++;
      $display("FAIL basic_data: got %0d rsp, first %h, required 1 rsp %h", got_q.size(), got_q[0], exp_q[0]);
    end
  endtask

  task automatic test_wmask();
    int st;
    exp_q.delete(); got_q.delete();
    bus.rsp_ready = 1'b1;
    send(1'b1, 4'hF, 8'h20, 32'h11223344, st);
    send(1'b1, 4'b0101, 8'h20, 32'hAABBCCDD, st);
    send(1'b0, 4'h0, 8'h20, 32'h0, st);
    drain();
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 32'h11BB33DD || exp_q[0] !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL wmask_merge: got %h (model %h), required 11bb33dd", got_q[0], exp_q[0]);
    end
  endtask

  task automatic test_backpressure();
    int st;
    logic [7:0] a [6];
    logic ok;
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 6; k++) a[k] = 8'($urandom_range(0, 255));
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b0, 4'h0, a[k], 32'h0, st);
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready_drop: req_ready=%b, required 0", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a[4];
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sram_csb !== 1'b1 || bus.req_ready !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL bp_stall: csb=%b ready=%b during stall, required 1 0", sram_csb, bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_return: req_ready=%b, required 1", bus.req_ready);
    end
    exp_q.push_back(ref_mem[a[4]]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    send(1'b0, 4'h0, a[5], 32'h0, st);
    drain();
    n_cmp++;
    if (got_q.size() != 6) begin
      n_err++;
      $display("FAIL bp_count: got %0d responses, required 6", got_q.size());
    end
    for (int k = 0; k < got_q.size() && k < 6; k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL bp_data[%0d]: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int st;
    exp_q.delete(); got_q.delete();
    bus.rsp_ready = 1'b1;
    send(1'b1, 4'hF, 8'h05, 32'hCAFE0001, st);
    send(1'b0, 4'h0, 8'h05, 32'h0, st);
    n_cmp++;
    if ({sram_csb, sram_web} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_rd_drive: csb=%b web=%b, required 0 1", sram_csb, sram_web);
    end
    @(negedge clk);
    n_cmp++;
    if ({sram_csb, sram_web} !== 2'b11) begin
      n_err++;
      $display("FAIL b2b_idle: csb=%b web=%b, required 1 1", sram_csb, sram_web);
    end
    drain();
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 32'hCAFE0001) begin
      n_err++;
      $display("FAIL b2b_data: got %h (%0d rsp), required cafe0001", got_q[0], got_q.size());
    end
  endtask

  task automatic test_random();
    int st;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 80; i++) begin
      bus.rsp_ready = 1'($urandom);
      send(1'($urandom), 4'($urandom), 8'($urandom_range(0, 15)), $urandom, st);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rand_count: got %0d responses, required %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL rand_data[%0d]: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int st;
    logic ok;
    exp_q.delete(); got_q.delete();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(1'b0, 4'h0, 8'($urandom), 32'h0, st);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sram_csb, bus.rsp_valid, bus.req_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL midrst_now: csb=%b rsp_valid=%b ready=%b, required 1 0 0", sram_csb, bus.rsp_valid, bus.req_ready);
    end
    exp_q.delete(); got_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL midrst_stale: rsp_valid seen 1 after reset, required 0");
    end
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(1'b0, 4'h0, 8'($urandom), 32'h0, st);
      if (st != 0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok || bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_credit: stall=%b ready=%b after 4 reads, required 0 0", !ok, bus.req_ready);
    end
    drain();
    n_cmp++;
    if (got_q.size() != 4 || got_q != exp_q) begin
      n_err++;
      $display("FAIL midrst_data: got %0d responses, required 4 matching model", got_q.size());
    end
  endtask

`ifdef SRAM_REQ_BRIDGE_STATS_EN
  task automatic test_stats();
    int st;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete(); got_q.delete();
    bus.rsp_ready = 1'b1;
    send(1'b0, 4'h0, 8'h01, 32'h0, st);
    send(1'b1, 4'hF, 8'h02, 32'h12345678, st);
    send(1'b0, 4'h0, 8'h02, 32'h0, st);
    send(1'b1, 4'h0, 8'h03, 32'h0, st);
    send(1'b0, 4'h0, 8'h03, 32'h0, st);
    drain();
    n_cmp++;
    if (stat_rd_cnt !== 16'd3 || stat_wr_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL stats_small: rd=%0d wr=%0d, required 3 2", stat_rd_cnt, stat_wr_cnt);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    repeat (70000) @(negedge clk);
    bus.req_valid = 1'b0;
    drain();
    got_q.delete(); exp_q.delete();
    n_cmp++;
    if (stat_rd_cnt !== 16'hFFFF || stat_wr_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL stats_sat: rd=%h wr=%0d, required ffff 2", stat_rd_cnt, stat_wr_cnt);
    end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_wmask = 4'h0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_fill();
    test_basic();
    test_wmask();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SRAM_REQ_BRIDGE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
